// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage pipelined NxN unsigned approximate multiplier.
//   S1: partial-product matrix register.
//   S2: low columns (weights < APPROX_COLS) OR-compressed with or_4 trees,
//       columns >= APPROX_COLS reduced exactly to a carry-save pair with 4:2/3:2 cells.
//   S3: final carry-propagate add, low OR bits merged in.
// Global stall: every stage holds while the product in S3 is not taken.
// Optional build macro APPROX_ERR_STATS_EN adds err_count, a saturating count
// of delivered products that differ from the exact a*b.
module approx_mult_pipe #(
  parameter int N           = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
`ifdef APPROX_ERR_STATS_EN
  ,
  output logic [15:0]    err_count
`endif
);

  localparam int W  = 2 * N;
  localparam int K  = APPROX_COLS;
  // L needs at least one bit so the vector stays legal when K = 0; it is then tied to 0.
  localparam int LW = (K > 0) ? K : 1;
  localparam int NG = (N + 3) / 4;

  // Bits of weight >= K belong to the exact part; everything below is approximated.
  function automatic logic [W-1:0] f_hmask();
    logic [W-1:0] m;
    for (int k = 0; k < W; k++) begin
      m[k] = (k >= K);
    end
    return m;
  endfunction

  localparam logic [W-1:0] HMASK = f_hmask();

  // or_4 approximate compressor cell.
  function automatic logic f_or4(input logic [3:0] x);
    return x[0] | x[1] | x[2] | x[3];
  endfunction

  // 3:2 carry-save cell across a whole vector; returns {carry, sum}.
  // The carry out of the top bit is always zero because the exact part fits in W bits.
  function automatic logic [2*W-1:0] f_csa32(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic [W-1:0] z);
    logic [W-1:0] s;
    logic [W-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  // 4:2 compressor built from two chained 3:2 cells; returns {carry, sum}.
  function automatic logic [2*W-1:0] f_csa42(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic [W-1:0] z,
                                             input logic [W-1:0] u);
    logic [2*W-1:0] t;
    t = f_csa32(x, y, z);
    return f_csa32(t[W-1:0], t[2*W-1:W], u);
  endfunction

  logic                  w_advance;
  logic                  r_v1;
  logic                  r_v2;
  logic                  r_v3;
  // r_pp[j][i] = a[i] & b[j], weight i+j
  logic [N-1:0][N-1:0]   r_pp;
  logic [LW-1:0]         r_l;
  logic [W-1:0]          r_sum;
  logic [W-1:0]          r_carry;
  logic [W-1:0]          r_p;

  logic [LW-1:0]         w_l;
  logic [W-1:0]          w_sum;
  logic [W-1:0]          w_carry;
  logic [W-1:0]          w_p;
  logic [N-1:0][W-1:0]   w_rows;
  logic [4*NG-1:0]       w_col;
  logic                  w_col_or;
  logic [2*W-1:0]        w_cs;

  assign w_advance = !(r_v3 && !out_ready);
  assign in_ready  = w_advance && !rst;
  assign out_valid = r_v3;
  assign p         = r_p;

  // S1: capture the partial-product matrix of the incoming operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
    end else if (w_advance) begin
      r_v1 <= in_valid;
      for (int j = 0; j < N; j++) begin
        r_pp[j] <= a & {N{b[j]}};
      end
    end
  end

  // S2 combinational: OR-compress the low columns, carry-save reduce the high ones.
  always_comb begin
    w_l      = '0;
    w_col    = '0;
    w_col_or = 1'b0;
    w_rows   = '0;
    w_cs     = '0;
    w_sum    = '0;
    w_carry  = '0;

    for (int k = 0; k < LW; k++) begin
      if (k < K) begin
        w_col    = '0;
        w_col_or = 1'b0;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            if (i + j == k) begin
              w_col[i] = r_pp[j][i];
            end
          end
        end
        for (int g = 0; g < NG; g++) begin
          w_col_or = w_col_or | f_or4(w_col[4*g +: 4]);
        end
        w_l[k] = w_col_or;
      end
    end

    for (int j = 0; j < N; j++) begin
      w_rows[j] = (W'(r_pp[j]) << j) & HMASK;
    end

    w_sum   = w_rows[0];
    w_carry = '0;
    for (int j = 1; j < N; j += 2) begin
      if (j + 1 < N) begin
        w_cs = f_csa42(w_sum, w_carry, w_rows[j], w_rows[j+1]);
      end else begin
        w_cs = f_csa32(w_sum, w_carry, w_rows[j]);
      end
      w_sum   = w_cs[W-1:0];
      w_carry = w_cs[2*W-1:W];
    end
  end

  // S2: register the approximate low bits and the carry-save pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
    end else if (w_advance) begin
      r_v2    <= r_v1;
      r_l     <= w_l;
      r_sum   <= w_sum;
      r_carry <= w_carry;
    end
  end

  // S3 combinational: final add; the exact part is zero below bit K so the OR cannot collide.
  always_comb begin
    w_p = (r_sum + r_carry) | W'(r_l);
  end

  // S3: product register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3 <= 1'b0;
      r_p  <= '0;
    end else if (w_advance) begin
      r_v3 <= r_v2;
      r_p  <= w_p;
    end
  end

`ifdef APPROX_ERR_STATS_EN
  logic [W-1:0] r_ex1;
  logic [W-1:0] r_ex2;
  logic [W-1:0] r_ex3;
  logic [15:0]  r_err;

  // Exact product travels alongside the approximate one; count delivered mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      if (w_advance) begin
        r_ex1 <= W'(a) * W'(b);
        r_ex2 <= r_ex1;
        r_ex3 <= r_ex2;
      end
      if (r_v3 && out_ready && (r_p != r_ex3) && (r_err != 16'hFFFF)) begin
        r_err <= r_err + 16'd1;
      end
    end
  end

  assign err_count = r_err;
`endif

endmodule
